// File: rtl/game_status_ctrl.sv
// Game phase controller: INIT/WAIT/GAME/WIN/LOSE sequencing, hit points with a
// post-hit invulnerability window, and a saturating volume setting.
module game_status_ctrl #(
  parameter int unsigned MAX_HP       = 7,
  parameter int unsigned MAX_VOL      = 5,
  parameter int unsigned INIT_VOL     = 3,
  parameter int unsigned WAIT_HSECS   = 6,
  parameter int unsigned END_HSECS    = 10,
  parameter int unsigned INVULN_HSECS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       div_hsec,
  input  logic       btn_start,
  input  logic       btn_vol_up,
  input  logic       btn_vol_down,
  input  logic       hit,
  input  logic       goal,
  output logic [2:0] state,
  output logic [2:0] curr_hp,
  output logic [2:0] volume,
  output logic       hp_lost
);

  localparam int unsigned HSEC_MAX = (WAIT_HSECS > END_HSECS) ? WAIT_HSECS : END_HSECS;
  localparam int unsigned HSEC_W   = (HSEC_MAX > 1) ? $clog2(HSEC_MAX) : 1;
  localparam int unsigned INV_W    = $clog2(INVULN_HSECS + 1);

  localparam logic [2:0]        HP_FULL  = 3'(MAX_HP);
  localparam logic [2:0]        VOL_TOP  = 3'(MAX_VOL);
  localparam logic [2:0]        VOL_RST  = 3'(INIT_VOL);
  localparam logic [HSEC_W-1:0] WAIT_END = HSEC_W'(WAIT_HSECS - 1);
  localparam logic [HSEC_W-1:0] END_END  = HSEC_W'(END_HSECS - 1);
  localparam logic [INV_W-1:0]  INV_LOAD = INV_W'(INVULN_HSECS);

  typedef enum logic [2:0] {
    S_INIT = 3'b000,
    S_WAIT = 3'b001,
    S_GAME = 3'b010,
    S_WIN  = 3'b011,
    S_LOSE = 3'b100
  } state_t;

  state_t            state_q, state_n;
  logic [2:0]        hp_q, hp_n;
  logic [2:0]        vol_q, vol_n;
  logic              lost_q, lost_n;
  logic [HSEC_W-1:0] hsec_q, hsec_n;
  logic [INV_W-1:0]  inv_q, inv_n;
  logic              div_d;
  logic              tick;

  assign tick = div_hsec & ~div_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_INIT;
      hp_q    <= HP_FULL;
      vol_q   <= VOL_RST;
      lost_q  <= 1'b0;
      hsec_q  <= '0;
      inv_q   <= '0;
      div_d   <= 1'b0;
    end else begin
      state_q <= state_n;
      hp_q    <= hp_n;
      vol_q   <= vol_n;
      lost_q  <= lost_n;
      hsec_q  <= hsec_n;
      inv_q   <= inv_n;
      div_d   <= div_hsec;
    end
  end

  always_comb begin
    vol_n = vol_q;
    if (btn_vol_up && !btn_vol_down) begin
      vol_n = (vol_q >= VOL_TOP) ? VOL_TOP : vol_q + 3'd1;
    end else if (btn_vol_down && !btn_vol_up) begin
      vol_n = (vol_q == 3'd0) ? 3'd0 : vol_q - 3'd1;
    end
  end

  always_comb begin
    state_n = state_q;
    hp_n    = hp_q;
    lost_n  = 1'b0;
    hsec_n  = hsec_q;
    inv_n   = inv_q;

    case (state_q)
      S_INIT: begin
        if (btn_start) begin
          state_n = S_WAIT;
          hsec_n  = '0;
        end
      end

      S_WAIT: begin
        if (tick) begin
          if (hsec_q == WAIT_END) begin
            state_n = S_GAME;
            hp_n    = HP_FULL;
            inv_n   = '0;
            hsec_n  = '0;
          end else begin
            hsec_n = hsec_q + HSEC_W'(1);
          end
        end
      end

      S_GAME: begin
        if (goal) begin
          state_n = S_WIN;
          hsec_n  = '0;
          inv_n   = '0;
        end else begin
          // A hit is judged against the pre-tick counter, so a hit landing on
          // the tick that expires the window is still dropped.
          if (tick && inv_q != '0) begin
            inv_n = inv_q - INV_W'(1);
          end
          if (hit && inv_q == '0) begin
            hp_n   = hp_q - 3'd1;
            lost_n = 1'b1;
            inv_n  = INV_LOAD;
            if (hp_q == 3'd1) begin
              state_n = S_LOSE;
              hsec_n  = '0;
              inv_n   = '0;
            end
          end
        end
      end

      S_WIN, S_LOSE: begin
        if (btn_start || (tick && hsec_q == END_END)) begin
          state_n = S_INIT;
          hp_n    = HP_FULL;
          hsec_n  = '0;
        end else if (tick) begin
          hsec_n = hsec_q + HSEC_W'(1);
        end
      end

      default: begin
        state_n = S_INIT;
        hp_n    = HP_FULL;
        hsec_n  = '0;
        inv_n   = '0;
      end
    endcase
  end

  assign state   = state_q;
  assign curr_hp = hp_q;
  assign volume  = vol_q;
  assign hp_lost = lost_q;

endmodule

// File: doc/game_status_ctrl.md
Name: game_status_ctrl

Overview:
Produces the game-phase code, current hit points and volume level that the LED status driver and other display blocks consume. Takes one-cycle button and event pulses plus the half-second divider output. Runs the INIT -> WAIT -> GAME -> WIN/LOSE -> INIT phase machine, tracks HP with a post-hit invulnerability window, and holds the volume setting. All outputs are registered and sit on the system clock domain.

Parameters:
MAX_HP, 7, HP loaded at reset and on entry to GAME (1..7).
MAX_VOL, 5, upper volume saturation (1..7).
INIT_VOL, 3, volume after reset (0..MAX_VOL).
WAIT_HSECS, 6, half-second ticks spent in WAIT before GAME (>=1).
END_HSECS, 10, half-second ticks spent in WIN/LOSE before auto-return to INIT (>=1).
INVULN_HSECS, 2, ticks after a counted hit during which further hits are ignored (>=1).

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  reset, asynchronous, active-low (asserted at 0).
div_hsec  in  1  half-second divider output, synchronous to clk; rising edge = one tick.
btn_start  in  1  one-cycle pulse, start/skip.
btn_vol_up  in  1  one-cycle pulse, volume +1.
btn_vol_down  in  1  one-cycle pulse, volume -1.
hit  in  1  one-cycle pulse, player damaged.
goal  in  1  one-cycle pulse, win condition reached.
state  out  3  INIT=000, WAIT=001, GAME=010, WIN=011, LOSE=100.
curr_hp  out  3  current HP, 0..MAX_HP.
volume  out  3  current volume, 0..MAX_VOL.
hp_lost  out  1  one-cycle pulse on each counted hit.

Behaviour:
- Reset (rst=0, async): state=INIT, curr_hp=MAX_HP, volume=INIT_VOL, hp_lost=0, hsec_cnt=0, invuln_cnt=0, div_hsec_d=0.
- Tick: tick = div_hsec & ~div_hsec_d; div_hsec_d is registered each cycle. A held-high div_hsec yields one tick.
- All outputs are registered and update on the clk edge that samples the input pulse (visible the cycle after the pulse).
- Volume, in any state: up only -> min(volume+1, MAX_VOL); down only -> max(volume-1, 0); both in the same cycle -> unchanged.
- INIT: btn_start -> WAIT, hsec_cnt=0. hit and goal are ignored.
- WAIT: each tick increments hsec_cnt. A tick with hsec_cnt==WAIT_HSECS-1 -> GAME, curr_hp=MAX_HP, invuln_cnt=0, hsec_cnt=0. btn_start, hit and goal are ignored.
- GAME:
  - goal -> WIN, hsec_cnt=0. goal takes priority over a simultaneous hit (HP unchanged, no hp_lost).
  - hit with invuln_cnt==0 -> curr_hp-1, hp_lost=1 for one cycle, invuln_cnt=INVULN_HSECS. If the new HP is 0, state -> LOSE on the same edge, hsec_cnt=0.
  - hit with invuln_cnt!=0 is dropped.
  - Each tick decrements invuln_cnt if nonzero. A tick and a hit in the same cycle with invuln_cnt==1 -> the hit is dropped, invuln_cnt becomes 0.
- WIN / LOSE: curr_hp holds its value. Each tick increments hsec_cnt. A tick with hsec_cnt==END_HSECS-1, or a btn_start pulse, -> INIT, curr_hp=MAX_HP, hsec_cnt=0. hit and goal are ignored.
- Undefined state codes -> INIT on the next edge, curr_hp=MAX_HP.
- Counter widths are sized to their parameters. No wrap is possible: each counter is cleared on state exit.
- Reset mid-game returns all outputs to reset values asynchronously. Volume does not survive reset.

Test Plan:
- Reset, then btn_vol_up x3 -> volume 3->4->5->5 (saturates). btn_vol_down x6 -> volume reaches 0 and holds. Up and down in the same cycle at volume 2 -> stays 2.
- btn_start in INIT, then 6 rising edges of div_hsec (div_hsec held high 3 cycles each) -> state stays 001 through 5 ticks and becomes 010 after the 6th tick, curr_hp=7.
- In GAME: hit -> curr_hp 6, hp_lost pulse. Hit 1 cycle later -> ignored. After 2 ticks, hit -> curr_hp 5. Hit coincident with the tick that brings invuln_cnt to 0 -> ignored.
- Drive spaced hits from HP 7 to 0 -> 7th counted hit gives curr_hp 0 and state 100 on the same edge. After 10 ticks -> state 000, curr_hp 7.
- In GAME, hit and goal in the same cycle -> state 011, curr_hp unchanged, hp_lost 0. btn_start 2 ticks later -> state 000.
- Assert rst=0 mid-GAME between clock edges -> state 000, curr_hp 7, volume 3 immediately, without waiting for a clk edge.
